// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle fetch/decode/execute controller for the 16-bit CPU datapath.
// Handles BRAM wait states, stall freeze, halt, level interrupts and a retired-instruction count.
module mc_ctrl_fsm #(
    parameter int MEM_LAT  = 0,
    parameter int IRQ_EN   = 1,
    parameter int LINK_REG = 15,
    parameter int CNT_W    = 16
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [2:0]       i_instr_type,
    input  logic             i_stall,
    input  logic             i_irq,
    output logic             o_pc_enable,
    output logic             o_ir_enable,
    output logic             o_r_enable,
    output logic             o_alu_bus_sel,
    output logic             o_reg_read,
    output logic             o_mem_we,
    output logic             o_flags_enable,
    output logic             o_link_en,
    output logic             o_dest_force,
    output logic             o_vec_load,
    output logic             o_irq_ack,
    output logic             o_halted,
    output logic [CNT_W-1:0] o_retired
);

    if (CNT_W < 1 || MEM_LAT < 0 || MEM_LAT > 3 || LINK_REG < 0 || LINK_REG > 15) begin : g_bad_param
        $error("mc_ctrl_fsm: parameter out of range");
    end

    localparam logic [1:0] LAT = 2'(MEM_LAT);

    localparam logic [11:0] C_PC  = 12'h001;
    localparam logic [11:0] C_IR  = 12'h002;
    localparam logic [11:0] C_RE  = 12'h004;
    localparam logic [11:0] C_ALU = 12'h008;
    localparam logic [11:0] C_RR  = 12'h010;
    localparam logic [11:0] C_WE  = 12'h020;
    localparam logic [11:0] C_FL  = 12'h040;
    localparam logic [11:0] C_LNK = 12'h080;
    localparam logic [11:0] C_DF  = 12'h100;
    localparam logic [11:0] C_VL  = 12'h200;
    localparam logic [11:0] C_ACK = 12'h400;
    localparam logic [11:0] C_HLT = 12'h800;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_WAIT_F = 4'd1,
        S_LATCH  = 4'd2,
        S_DECODE = 4'd3,
        S_EXEC   = 4'd4,
        S_MADDR  = 4'd5,
        S_WAIT_M = 4'd6,
        S_LDWB   = 4'd7,
        S_STWR   = 4'd8,
        S_BRJ    = 4'd9,
        S_LINK   = 4'd10,
        S_HALT   = 4'd11,
        S_IRQ    = 4'd12
    } state_t;

    state_t           r_state;
    logic [1:0]       r_wcnt;
    logic [CNT_W-1:0] r_retired;
    logic [11:0]      r_ctrl;

    state_t           w_nxt;
    logic [1:0]       w_wcnt_nxt;
    logic             w_retire;
    logic             w_irq;
    logic             w_legal;
    logic [11:0]      w_ctrl;

    // Address stays on the register path through the load wait states.
    function automatic logic [11:0] f_dec(state_t s);
        logic [11:0] c;
        c = '0;
        case (s)
            S_LATCH:          c = C_IR;
            S_EXEC:           c = C_PC | C_RE | C_ALU | C_FL;
            S_MADDR, S_WAIT_M: c = C_RR;
            S_LDWB:           c = C_RR | C_RE | C_PC;
            S_STWR:           c = C_RR | C_WE | C_PC;
            S_BRJ:            c = C_PC;
            S_LINK:           c = C_LNK | C_RE | C_PC;
            S_HALT:           c = C_HLT;
            S_IRQ:            c = ((IRQ_EN != 0) ? C_ACK : 12'h000) | C_LNK | C_DF | C_RE | C_VL | C_PC;
            default:          c = '0;
        endcase
        return c;
    endfunction

    assign w_irq   = (IRQ_EN != 0) && i_irq;
    assign w_legal = (r_state <= S_IRQ);

    always_comb begin
        w_nxt      = r_state;
        w_wcnt_nxt = r_wcnt;
        w_retire   = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_wcnt_nxt = LAT;
                w_nxt      = (LAT != 2'd0) ? S_WAIT_F : S_LATCH;
            end
            S_WAIT_F: begin
                w_wcnt_nxt = r_wcnt - 2'd1;
                if (r_wcnt <= 2'd1) w_nxt = S_LATCH;
            end
            S_LATCH:  w_nxt = S_DECODE;
            S_DECODE: begin
                case (i_instr_type)
                    3'd0, 3'd1: w_nxt = S_EXEC;
                    3'd2:       w_nxt = S_MADDR;
                    3'd3:       w_nxt = S_STWR;
                    3'd4, 3'd5: w_nxt = S_BRJ;
                    3'd6:       w_nxt = S_LINK;
                    default:    w_nxt = S_HALT;
                endcase
            end
            S_MADDR: begin
                w_wcnt_nxt = LAT;
                w_nxt      = (LAT != 2'd0) ? S_WAIT_M : S_LDWB;
            end
            S_WAIT_M: begin
                w_wcnt_nxt = r_wcnt - 2'd1;
                if (r_wcnt <= 2'd1) w_nxt = S_LDWB;
            end
            S_EXEC, S_LDWB, S_STWR, S_BRJ, S_LINK: begin
                w_retire = 1'b1;
                w_nxt    = w_irq ? S_IRQ : S_FETCH;
            end
            S_HALT:  if (w_irq) w_nxt = S_IRQ;
            S_IRQ:   w_nxt = S_FETCH;
            default: w_nxt = S_FETCH;
        endcase
        // Stall freezes everything, but an illegal encoding still recovers.
        if (i_stall && w_legal) begin
            w_nxt      = r_state;
            w_wcnt_nxt = r_wcnt;
            w_retire   = 1'b0;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state   <= S_FETCH;
            r_wcnt    <= 2'd0;
            r_retired <= '0;
            r_ctrl    <= '0;
        end else begin
            r_state <= w_nxt;
            r_wcnt  <= w_wcnt_nxt;
            r_ctrl  <= f_dec(w_nxt);
            if (w_retire) r_retired <= r_retired + CNT_W'(1);
        end
    end

    assign w_ctrl = i_stall ? 12'h000 : r_ctrl;

    assign o_pc_enable    = w_ctrl[0];
    assign o_ir_enable    = w_ctrl[1];
    assign o_r_enable     = w_ctrl[2];
    assign o_alu_bus_sel  = w_ctrl[3];
    assign o_reg_read     = w_ctrl[4];
    assign o_mem_we       = w_ctrl[5];
    assign o_flags_enable = w_ctrl[6];
    assign o_link_en      = w_ctrl[7];
    assign o_dest_force   = w_ctrl[8];
    assign o_vec_load     = w_ctrl[9];
    assign o_irq_ack      = w_ctrl[10];
    assign o_halted       = w_ctrl[11];
    assign o_retired      = r_retired;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Scoreboard bench for mc_ctrl_fsm: two instances (MEM_LAT=0/CNT_W=16 and MEM_LAT=2/CNT_W=4)
// driven with random instruction streams, stalls, interrupts and resets.
module tb_mc_ctrl_fsm;

    localparam logic [11:0] PC  = 12'h001;
    localparam logic [11:0] IR  = 12'h002;
    localparam logic [11:0] RE  = 12'h004;
    localparam logic [11:0] ALU = 12'h008;
    localparam logic [11:0] RR  = 12'h010;
    localparam logic [11:0] WE  = 12'h020;
    localparam logic [11:0] FL  = 12'h040;
    localparam logic [11:0] LNK = 12'h080;
    localparam logic [11:0] DF  = 12'h100;
    localparam logic [11:0] VL  = 12'h200;
    localparam logic [11:0] ACK = 12'h400;
    localparam logic [11:0] HLT = 12'h800;

    typedef struct packed {
        logic [11:0] v;
        logic [15:0] r;
    } exp_t;

    logic       clk;
    logic [1:0] rst_v, stall_v, irq_v;
    logic [2:0] it_v [2];
    logic [1:0] pc_en, ir_en, r_en, alu_sel, rreg, we, fl_en, lnk, dfc, vl, ack, hlt;
    logic [15:0] ret0;
    logic [3:0]  ret1;

    exp_t q0[$];
    exp_t q1[$];
    int unsigned mret [2];
    int n_vec = 0;
    int n_fail = 0;

    mc_ctrl_fsm #(.MEM_LAT(0), .IRQ_EN(1), .LINK_REG(15), .CNT_W(16)) dut0 (
        .i_clk(clk), .i_reset(rst_v[0]), .i_instr_type(it_v[0]), .i_stall(stall_v[0]), .i_irq(irq_v[0]),
        .o_pc_enable(pc_en[0]), .o_ir_enable(ir_en[0]), .o_r_enable(r_en[0]), .o_alu_bus_sel(alu_sel[0]),
        .o_reg_read(rreg[0]), .o_mem_we(we[0]), .o_flags_enable(fl_en[0]), .o_link_en(lnk[0]),
        .o_dest_force(dfc[0]), .o_vec_load(vl[0]), .o_irq_ack(ack[0]), .o_halted(hlt[0]), .o_retired(ret0)
    );

    mc_ctrl_fsm #(.MEM_LAT(2), .IRQ_EN(1), .LINK_REG(15), .CNT_W(4)) dut1 (
        .i_clk(clk), .i_reset(rst_v[1]), .i_instr_type(it_v[1]), .i_stall(stall_v[1]), .i_irq(irq_v[1]),
        .o_pc_enable(pc_en[1]), .o_ir_enable(ir_en[1]), .o_r_enable(r_en[1]), .o_alu_bus_sel(alu_sel[1]),
        .o_reg_read(rreg[1]), .o_mem_we(we[1]), .o_flags_enable(fl_en[1]), .o_link_en(lnk[1]),
        .o_dest_force(dfc[1]), .o_vec_load(vl[1]), .o_irq_ack(ack[1]), .o_halted(hlt[1]), .o_retired(ret1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [11:0] act_vec(int d);
        return {hlt[d], ack[d], vl[d], dfc[d], lnk[d], fl_en[d], we[d], rreg[d],
                alu_sel[d], r_en[d], ir_en[d], pc_en[d]};
    endfunction

    function automatic int unsigned cnt_mask(int d);
        return (d == 0) ? 32'hFFFF : 32'hF;
    endfunction

    // One clock of stimulus plus the response the spec demands for that cycle.
    task automatic cyc(int d, bit r, bit s, bit q, logic [2:0] it, logic [11:0] ev);
        exp_t e;
        @(posedge clk);
        #1;
        rst_v[d]   = r;
        stall_v[d] = s;
        irq_v[d]   = q;
        it_v[d]    = it;
        if (r) mret[d] = 0;
        e.v = ev;
        e.r = 16'(mret[d]);
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    // Entry = {irq sample point, retire, control vector}; ab: -1 none, -2 random, else cycle index.
    task automatic run_instr(int d, logic [2:0] it, bit st_en, bit take, int hcnt, int ab);
        logic [13:0] ent[$];
        int lat, dec_i, i, abort_i;
        logic [2:0] itv;
        bit qv, done;
        lat = (d == 0) ? 0 : 2;
        for (int k = 0; k <= lat; k++) ent.push_back({2'b00, 12'h000});
        ent.push_back({2'b00, IR});
        dec_i = ent.size();
        ent.push_back({2'b00, 12'h000});
        case (it)
            3'd0, 3'd1: ent.push_back({2'b11, PC | RE | ALU | FL});
            3'd2: begin
                for (int k = 0; k <= lat; k++) ent.push_back({2'b00, RR});
                ent.push_back({2'b11, RR | RE | PC});
            end
            3'd3:       ent.push_back({2'b11, RR | WE | PC});
            3'd4, 3'd5: ent.push_back({2'b11, PC});
            3'd6:       ent.push_back({2'b11, LNK | RE | PC});
            default: begin
                for (int k = 0; k < hcnt; k++) ent.push_back({2'b00, HLT});
                ent.push_back({2'b10, HLT});
            end
        endcase
        abort_i = (ab == -2) ? int'($urandom_range(0, ent.size() - 1)) : ab;
        i = 0;
        while (i < ent.size()) begin
            if (i == abort_i) begin
                cyc(d, 1'b1, 1'b0, 1'b0, 3'd0, 12'h000);
                cyc(d, 1'b1, 1'b0, 1'b0, 3'd0, 12'h000);
                return;
            end
            itv = (i == dec_i) ? it : 3'($urandom_range(0, 7));
            if (st_en && $urandom_range(0, 4) == 0) begin
                cyc(d, 1'b0, 1'b1, 1'($urandom_range(0, 1)), itv, 12'h000);
            end else begin
                qv = ent[i][13] ? take : ((it == 3'd7) ? 1'b0 : 1'($urandom_range(0, 1)));
                cyc(d, 1'b0, 1'b0, qv, itv, ent[i][11:0]);
                if (ent[i][12]) mret[d] = (mret[d] + 1) & cnt_mask(d);
                i++;
            end
        end
        if (take) begin
            done = 1'b0;
            while (!done) begin
                if (st_en && $urandom_range(0, 4) == 0) begin
                    cyc(d, 1'b0, 1'b1, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 12'h000);
                end else begin
                    cyc(d, 1'b0, 1'b0, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                        ACK | LNK | DF | RE | VL | PC);
                    done = 1'b1;
                end
            end
        end
    endtask

    task automatic drive(int d);
        logic [2:0] it;
        bit take;
        repeat (3) cyc(d, 1'b1, 1'b0, 1'b0, 3'd0, 12'h000);
        run_instr(d, (d == 0) ? 3'd0 : 3'd2, 1'b0, 1'b0, 0, -1);
        run_instr(d, 3'd3, 1'b0, 1'b0, 0, -1);
        run_instr(d, 3'd6, 1'b0, 1'b0, 0, -1);
        run_instr(d, 3'd7, 1'b0, 1'b1, 5, -1);
        run_instr(d, 3'd2, 1'b0, 1'b0, 0, (d == 0) ? 4 : 7);
        for (int n = 0; n < 300; n++) begin
            it   = 3'($urandom_range(0, 7));
            take = (it == 3'd7) ? 1'b1 : ($urandom_range(0, 4) == 0);
            run_instr(d, it, 1'b1, take, int'($urandom_range(1, 4)),
                      ($urandom_range(0, 29) == 0) ? -2 : -1);
        end
    endtask

    task automatic mon(int d);
        exp_t e;
        logic [11:0] av;
        logic [15:0] ar;
        forever begin
            @(negedge clk);
            if ((d == 0) ? (q0.size() != 0) : (q1.size() != 0)) begin
                if (d == 0) e = q0.pop_front();
                else        e = q1.pop_front();
                av = act_vec(d);
                ar = (d == 0) ? ret0 : {12'h000, ret1};
                n_vec++;
                if (av !== e.v || ar !== e.r) begin
                    n_fail++;
                    $display("FAIL dut%0d t=%0t ctrl act=%03h exp=%03h retired act=%0d exp=%0d",
                             d, $time, av, e.v, ar, e.r);
                end
            end
        end
    endtask

    initial begin
        rst_v   = 2'b11;
        stall_v = 2'b00;
        irq_v   = 2'b00;
        it_v[0] = 3'd0;
        it_v[1] = 3'd0;
        mret[0] = 0;
        mret[1] = 0;
        fork
            mon(0);
            mon(1);
        join_none
        fork
            drive(0);
            drive(1);
        join
        repeat (4) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
